// File: rtl/mem_bus_arbiter_pkg.sv
// Shared MemoryBus types for the N-master arbiter: command/result structs,
// arbitration mode and grant-FSM state encodings, plus an index-width helper.
// No ports; imported by mem_bus_arbiter and rr_picker.
package mem_bus_arbiter_pkg;

  localparam int DATA_W = 32;

  // Master/slave command: write data plus the start request level.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              start;
  } cmd_t;

  // Slave response: read data plus a single-cycle done strobe.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              done;
  } result_t;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Width of a master index; a single master still needs a 1-bit field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational winner selection for the arbiter.
// Ports: req_i (request vector), ptr_i (round-robin start index), mode_i
// (ARB_RR / ARB_FIXED) -> winner_o (granted index), valid_o (any request).
module rr_picker
  import mem_bus_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  localparam int IDX_W       = idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  input  arb_mode_t              mode_i,
  output logic [IDX_W-1:0]       winner_o,
  output logic                   valid_o
);

  logic             lo_vld;
  logic [IDX_W-1:0] lo_win;
  logic             hi_vld;
  logic [IDX_W-1:0] hi_win;

  // Two scans in one descending loop: lowest requester overall, and lowest
  // requester at or above the pointer. Round-robin prefers the latter and
  // falls back to the former, which is the wrap-around case.
  always_comb begin
    lo_vld = 1'b0;
    lo_win = '0;
    hi_vld = 1'b0;
    hi_win = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_vld = 1'b1;
        lo_win = IDX_W'(i);
        if (i >= int'(ptr_i)) begin
          hi_vld = 1'b1;
          hi_win = IDX_W'(i);
        end
      end
    end
    valid_o  = lo_vld;
    winner_o = (mode_i == ARB_RR && hi_vld) ? hi_win : lo_win;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master to 1-slave MemoryBus arbiter with registered grant FSM.
// Ports: clk_i/rst_ni; per-master m_address_i/m_we_i/m_cmd_i -> m_result_o;
// force_en_i/force_sel_i debug override; slave s_address_o/s_we_o/s_cmd_o <- s_result_i;
// grant_o one-hot owner; timeout_err_o one-cycle abort pulse.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS    = 2,
  parameter  int ADDR_W         = 30,
  parameter  int ARB_MODE       = 0,
  parameter  int TIMEOUT_CYCLES = 0,
  parameter  int CNT_W          = 16,
  localparam int IDX_W          = idx_w(NUM_MASTERS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [ADDR_W-1:0]      m_address_i [NUM_MASTERS],
  input  logic [NUM_MASTERS-1:0] m_we_i,
  input  cmd_t                   m_cmd_i     [NUM_MASTERS],
  output result_t                m_result_o  [NUM_MASTERS],
  input  logic                   force_en_i,
  input  logic [IDX_W-1:0]       force_sel_i,
  output logic [ADDR_W-1:0]      s_address_o,
  output logic                   s_we_o,
  output cmd_t                   s_cmd_o,
  input  result_t                s_result_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_err_o
);

  localparam arb_mode_t       MODE     = (ARB_MODE != 0) ? ARB_FIXED : ARB_RR;
  localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       last_owner_q, last_owner_d;
  logic                   masked_q, masked_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] req;
  logic [IDX_W-1:0]       win;
  logic                   win_vld;

  cmd_t                   own_cmd;
  logic [ADDR_W-1:0]      own_addr;
  logic                   own_we;
  logic                   tmo_hit;
  logic                   abort;
  logic                   finish;
  logic [IDX_W-1:0]       next_ptr;

  assign own_cmd  = m_cmd_i[owner_q];
  assign own_addr = m_address_i[owner_q];
  assign own_we   = m_we_i[owner_q];
  assign tmo_hit  = TMO_EN && (cnt_q == TMO_LAST);
  assign next_ptr = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
  assign grant_o  = grant_q;

  // The master that just finished still holds start for one cycle after its
  // done; masking it for the first IDLE cycle keeps that stale level from
  // being re-granted. Force mode narrows eligibility to a single index.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req[i] = m_cmd_i[i].start & ~(masked_q && (last_owner_q == IDX_W'(i)));
      if (force_en_i && (force_sel_i != IDX_W'(i))) begin
        req[i] = 1'b0;
      end
    end
  end

  rr_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .mode_i   (MODE),
    .winner_o (win),
    .valid_o  (win_vld)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    last_owner_d = last_owner_q;
    masked_d     = masked_q;
    cnt_d        = cnt_q;
    abort        = 1'b0;
    finish       = 1'b0;

    s_address_o   = '0;
    s_we_o        = 1'b0;
    s_cmd_o       = '0;
    timeout_err_o = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_result_o[i] = '0;
    end

    case (state_q)
      IDLE: begin
        masked_d = 1'b0;
        if (win_vld) begin
          owner_d = win;
          grant_d = NUM_MASTERS'(1) << win;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        s_address_o   = own_addr;
        s_we_o        = own_we;
        s_cmd_o       = own_cmd;
        s_cmd_o.start = 1'b1;
        cnt_d         = '0;
        state_d       = WAIT;
      end

      WAIT: begin
        s_address_o   = own_addr;
        s_we_o        = own_we;
        s_cmd_o       = own_cmd;
        s_cmd_o.start = 1'b0;

        // A real done always beats the timeout in the same cycle.
        if (s_result_i.done) begin
          finish = 1'b1;
        end else if (tmo_hit) begin
          abort  = 1'b1;
          finish = 1'b1;
        end else if (TMO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end

        timeout_err_o = abort;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (owner_q == IDX_W'(i)) begin
            m_result_o[i] = abort ? '{data: '0, done: 1'b1} : s_result_i;
          end
        end

        if (finish) begin
          state_d      = IDLE;
          grant_d      = '0;
          rr_ptr_d     = next_ptr;
          last_owner_d = owner_q;
          masked_d     = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      last_owner_q <= '0;
      masked_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      last_owner_q <= last_owner_d;
      masked_q     <= masked_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule
